// File: rtl/gate_net_pkg.sv
// rtl/gate_net_pkg.sv - shared types, defaults and network reference for the gate net sequencer
package gate_net_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam int DEF_SETTLE_CYCLES = 8;
    localparam int DEF_NUM_VEC       = 16;

    // abcd bit3=a, bit2=b, bit1=c, bit0=d
    function automatic logic net_expected(input logic [3:0] abcd);
        return (abcd[3] & abcd[2]) ^ (abcd[1] | abcd[0]);
    endfunction

endpackage

// File: rtl/gate_net_sequencer_if.sv
// rtl/gate_net_sequencer_if.sv - control, network drive and result bundle of the sequencer
interface gate_net_sequencer_if;
    logic       start;
    logic       abort;
    logic       z_in;
    logic [3:0] abcd_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic       fail_valid;
    logic [3:0] fail_vec;

    modport master (
        output start, abort, z_in,
        input  abcd_out, busy, done, pass, err_count, fail_valid, fail_vec
    );

    modport slave (
        input  start, abort, z_in,
        output abcd_out, busy, done, pass, err_count, fail_valid, fail_vec
    );
endinterface

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - loadable 8-bit down-counter with zero flag
module settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign zero = (count == 8'd0);

endmodule

// File: rtl/gate_net_sequencer.sv
// rtl/gate_net_sequencer.sv - walks all input vectors through a gate network and scores its output
module gate_net_sequencer
    import gate_net_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int NUM_VEC       = DEF_NUM_VEC
) (
    input logic                  clk,
    input logic                  rst_n,
    gate_net_sequencer_if.slave  bus
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LAST_VEC    = 4'(NUM_VEC - 1);

    state_t     state, state_next;
    logic [3:0] vec_idx;
    logic [3:0] abcd_q;
    logic [4:0] err_q, err_next;
    logic       fail_valid_q;
    logic [3:0] fail_vec_q;
    logic       pass_q;
    logic       done_q;
    logic       tmr_load, tmr_dec, tmr_zero;
    logic [7:0] tmr_load_val;
    logic       mismatch, last_vec;

    settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    assign mismatch = (state == ST_SAMPLE) && (bus.z_in != net_expected(abcd_q));
    assign last_vec = (vec_idx == LAST_VEC);
    assign err_next = (mismatch && err_q != 5'd31) ? err_q + 5'd1 : err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        tmr_load     = 1'b0;
        tmr_load_val = SETTLE_LOAD;
        tmr_dec      = 1'b0;
        if (bus.abort) begin
            // parking the timer at zero keeps an aborted run from leaking into the next
            state_next   = ST_IDLE;
            tmr_load     = 1'b1;
            tmr_load_val = '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: if (bus.start) state_next = ST_APPLY;
                ST_APPLY: begin
                    state_next = ST_SETTLE;
                    tmr_load   = 1'b1;
                end
                ST_SETTLE: begin
                    if (tmr_zero) state_next = ST_SAMPLE;
                    else          tmr_dec    = 1'b1;
                end
                ST_SAMPLE: state_next = last_vec ? ST_DONE : ST_APPLY;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_idx      <= '0;
            abcd_q       <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            pass_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort) begin
                abcd_q <= '0;
            end else begin
                unique case (state)
                    ST_IDLE, ST_DONE: begin
                        if (bus.start) begin
                            vec_idx      <= '0;
                            err_q        <= '0;
                            fail_valid_q <= 1'b0;
                            fail_vec_q   <= '0;
                            pass_q       <= 1'b0;
                        end
                    end
                    ST_APPLY: abcd_q <= vec_idx;
                    ST_SAMPLE: begin
                        err_q <= err_next;
                        if (mismatch && !fail_valid_q) begin
                            fail_vec_q   <= vec_idx;
                            fail_valid_q <= 1'b1;
                        end
                        // pass sees this sample's mismatch through err_next
                        if (last_vec) begin
                            done_q <= 1'b1;
                            pass_q <= (err_next == 5'd0);
                        end else begin
                            vec_idx <= vec_idx + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.abcd_out   = abcd_q;
    assign bus.busy       = (state == ST_APPLY) || (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_count  = err_q;
    assign bus.fail_valid = fail_valid_q;
    assign bus.fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_gate_net_sequencer.sv
// tb/tb_gate_net_sequencer.sv - randomized self-checking bench for gate_net_sequencer
module tb_gate_net_sequencer;

    localparam int SC = 8;
    localparam int NV = 16;
    localparam int PER = SC + 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gate_net_sequencer_if ifc ();
    gate_net_sequencer_if ifs ();

    gate_net_sequencer #(.SETTLE_CYCLES(SC), .NUM_VEC(NV)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc)
    );

    gate_net_sequencer #(.SETTLE_CYCLES(1), .NUM_VEC(1)) u_small (
        .clk(clk), .rst_n(rst_n), .bus(ifs)
    );

    int          total = 0;
    int          bad   = 0;
    int          mode  = 0;
    logic [15:0] mask  = '0;

    // gate-level network with and/or/xor delays of 3/1/3
    logic n_and, n_or, z_net;
    assign #3 n_and = ifc.abcd_out[3] & ifc.abcd_out[2];
    assign #1 n_or  = ifc.abcd_out[1] | ifc.abcd_out[0];
    assign #3 z_net = n_and ^ n_or;

    assign ifc.z_in = (mode == 0) ? z_net :
                      (mode == 1) ? 1'b0 :
                      (mode == 2) ? ~z_net :
                                    z_net ^ mask[ifc.abcd_out];
    assign ifs.z_in = (ifs.abcd_out[3] & ifs.abcd_out[2]) ^ (ifs.abcd_out[1] | ifs.abcd_out[0]);

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int good_z(input int v);
        return (((v >> 3) & (v >> 2)) & 1) ^ (((v >> 1) | v) & 1);
    endfunction

    function automatic int seen_z(input int md, input int v, input logic [15:0] m);
        case (md)
            0:       return good_z(v);
            1:       return 0;
            2:       return 1 - good_z(v);
            default: return good_z(v) ^ int'(m[v]);
        endcase
    endfunction

    // mismatch count and first failing index over vectors 0..n-1
    task automatic model(input int md, input logic [15:0] m, input int n,
                         output int errs, output int first);
        errs  = 0;
        first = -1;
        for (int v = 0; v < n; v++) begin
            if (seen_z(md, v, m) != good_z(v)) begin
                errs++;
                if (first < 0) first = v;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
    endtask

    task automatic run_big(input int md, input logic [15:0] m);
        int errs, first, dones, done_at;
        mode = md;
        mask = m;
        model(md, m, NV, errs, first);
        pulse_start();
        check("busy_apply", ifc.busy, 1);
        check("err_cleared", ifc.err_count, 0);
        dones   = 0;
        done_at = -1;
        for (int k = 1; k <= NV * PER + 4; k++) begin
            @(negedge clk);
            if (ifc.done) begin
                dones++;
                if (done_at < 0) done_at = k;
            end
            if (k < NV * PER && (k % PER) == 1)      check("abcd_apply", ifc.abcd_out, k / PER);
            if (k < NV * PER && (k % PER) == SC + 1) check("abcd_sample", ifc.abcd_out, k / PER);
        end
        check("done_cycle", done_at, NV * PER);
        check("done_count", dones, 1);
        check("busy_done", ifc.busy, 0);
        check("err_count", ifc.err_count, errs > 31 ? 31 : errs);
        check("pass", ifc.pass, errs == 0 ? 1 : 0);
        check("fail_valid", ifc.fail_valid, first >= 0 ? 1 : 0);
        check("fail_vec", ifc.fail_vec, first >= 0 ? first : 0);
    endtask

    task automatic abort_test();
        int errs, first, dones;
        logic [15:0] m;
        m    = 16'($urandom);
        mode = 3;
        mask = m;
        model(3, m, 5, errs, first);
        pulse_start();
        for (int k = 1; k <= 5 * PER + 3; k++) @(negedge clk);
        check("abort_pre_busy", ifc.busy, 1);
        check("abort_pre_abcd", ifc.abcd_out, 5);
        ifc.abort = 1'b1;
        @(negedge clk);
        ifc.abort = 1'b0;
        check("abort_busy", ifc.busy, 0);
        check("abort_abcd", ifc.abcd_out, 0);
        check("abort_done", ifc.done, 0);
        check("abort_pass", ifc.pass, 0);
        check("abort_err", ifc.err_count, errs);
        check("abort_fvalid", ifc.fail_valid, first >= 0 ? 1 : 0);
        check("abort_fvec", ifc.fail_vec, first >= 0 ? first : 0);
        dones = 0;
        for (int k = 0; k < 2 * PER; k++) begin
            @(negedge clk);
            if (ifc.done || ifc.busy) dones++;
        end
        check("abort_stays_idle", dones, 0);
        run_big(3, 16'($urandom));
    endtask

    task automatic reset_test();
        int wake;
        mode = 0;
        pulse_start();
        for (int k = 1; k <= 2 * PER + 3; k++) @(negedge clk);
        check("rst_pre_busy", ifc.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_abcd", ifc.abcd_out, 0);
        check("rst_busy", ifc.busy, 0);
        check("rst_done", ifc.done, 0);
        check("rst_pass", ifc.pass, 0);
        check("rst_err", ifc.err_count, 0);
        check("rst_fvalid", ifc.fail_valid, 0);
        check("rst_fvec", ifc.fail_vec, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wake = 0;
        for (int k = 0; k < 2 * PER; k++) begin
            @(negedge clk);
            if (ifc.busy || ifc.done || ifc.abcd_out != 4'd0) wake++;
        end
        check("rst_no_resume", wake, 0);
    endtask

    task automatic small_test();
        int done_at, busy_seen;
        @(negedge clk);
        ifs.start = 1'b1;
        ifs.abort = 1'b1;
        @(negedge clk);
        ifs.start = 1'b0;
        ifs.abort = 1'b0;
        busy_seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (ifs.busy || ifs.done) busy_seen++;
            @(negedge clk);
        end
        check("small_abort_wins", busy_seen, 0);
        ifs.start = 1'b1;
        @(negedge clk);
        ifs.start = 1'b0;
        done_at = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (ifs.done && done_at < 0) done_at = k;
        end
        check("small_done_cycle", done_at, 3);
        check("small_pass", ifs.pass, 1);
        check("small_err", ifs.err_count, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        ifc.start = 1'b0;
        ifc.abort = 1'b0;
        ifs.start = 1'b0;
        ifs.abort = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_abcd", ifc.abcd_out, 0);
        check("reset_busy", ifc.busy, 0);
        check("reset_done", ifc.done, 0);
        check("reset_pass", ifc.pass, 0);
        check("reset_err", ifc.err_count, 0);
        check("reset_fvalid", ifc.fail_valid, 0);
        check("reset_fvec", ifc.fail_vec, 0);
        rst_n = 1'b1;

        run_big(0, 16'h0000);
        run_big(1, 16'h0000);
        run_big(2, 16'h0000);
        run_big(3, 16'h8000);
        for (int i = 0; i < 4; i++) run_big(3, 16'($urandom));
        abort_test();
        reset_test();
        small_test();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
